instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder. Accepts decoded instruction fields over a valid/ready stream, encodes them into 32-bit RV32I words, and writes them sequentially into instruction memory.
- Used by boot/test infrastructure to load programs before the core is released.
- Format codes match the decoder's imm_sel encoding, so decoder output can drive this block back-to-back for round-trip checking.

Parameters:
- ADDR_W, 32, instruction memory byte-address width
- MAX_WORDS, 1024, upper bound on words per load session

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins session when IDLE
- base_addr  in  ADDR_W  first write address; sampled on start; bits[1:0] forced to 0
- num_words  in  16  words to write this session; sampled on start; 0 means immediate DONE
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid&&in_ready
- in_fmt  in  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J; others illegal
- in_opcode  in  7  opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U
- mem_we  out  1  write strobe, held until mem_ready
- mem_ready  in  1  memory accepts write when mem_we&&mem_ready
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DONE->IDLE
- err  out  1  sticky; set on any rejected bundle, cleared on start
- err_cnt  out  8  rejected bundles this session, saturates at 255

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE --start--> LOAD, or --start with num_words==0--> DONE.
  - LOAD --last word write handshake (written==num_words)--> DONE.
  - DONE --> IDLE unconditionally; done=1 for exactly that cycle.
- start outside IDLE is ignored.
- in_ready = (state==LOAD) && (!mem_we || mem_ready) && (accepted < num_words). Never asserted in IDLE or DONE.
- Latency: accepted bundle appears on mem_we/mem_addr/mem_wdata the next cycle. Full throughput of 1 word/cycle while mem_ready=1.
- mem_addr starts at base_addr and advances by 4 after each write handshake. Wraps modulo 2^ADDR_W silently.
- Encoding (bit ranges MSB->LSB):
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Validity checks; a failing bundle is consumed but no write is issued:
  - fmt/opcode pairing: R=0110011; I=0010011/0000011/1100111; S=0100011; B=1100011; U=0110111/0010111; J=1101111.
  - Immediate range: I/S in [-2048,2047]; B in [-4096,4094] and even; J in [-2^20, 2^20-2] and even; U requires imm[11:0]==0.
  - Illegal fmt code.
- On a rejected bundle: err<=1, err_cnt+1 (saturating), and the bundle counts toward accepted but not written. The session ends when accepted==num_words and the output register is drained, so rejects shorten the loaded image.
- Simultaneous write handshake and new accept: the output register reloads the same cycle, with no bubble.
- mem_ready low: mem_we, mem_addr and mem_wdata hold stable; in_ready drops.
- Asynchronous reset mid-session: immediate return to IDLE; any pending write is dropped (mem_we=0).

Decomposition:
- Shared package holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - format codes FMT_R..FMT_J, identical to the decoder's imm_sel values
  - state enum.
- One sub-module: instr_pack, purely combinational. Inputs are the fields; outputs are word[31:0] and legal. The FSM, counters and output register stay in the top module.

Test Plan:
- start base=0x100, num=3; ADDI x1,x0,5 (I), ADD x3,x1,x2 (R), SW x3,8(x0) (S), mem_ready=1. Required: writes 0x00500093@0x100, 0x002081B3@0x104, 0x00302423@0x108; done one cycle after the last write; err=0.
- B imm=-8, rs1=1, rs2=2, funct3=000, then J imm=2048, rd=1. Required: words 0xFE208CE3 and 0x001000EF.
- LUI rd=5 imm=0x12345000 → 0x123452B7. Then LUI imm=0x12345001 → no write; err=1, err_cnt=1.
- fmt=S with opcode 0110011 → rejected, no write. I imm=2048 → rejected. Required: err_cnt=2; session with num=2 ends with no writes.
- mem_ready held low 5 cycles during a 4-word burst. Required: address/data stable while stalled; in_ready=0 while stalled; no word lost or duplicated.
- rst_n asserted mid-burst, then released and start issued. Required: all outputs 0 immediately on reset; the new session begins at the new base address.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: RV32I opcodes,
// format codes (same values as the decoder's imm_sel), the loader state
// enum and a signed-range helper.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Plain 3-bit codes rather than an enum: 110/111 must stay representable
  // so they can be detected and rejected.
  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_I = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_J = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when v is representable as a 'bits'-wide two's complement value,
  // i.e. every bit above the sign bit equals the sign bit.
  function automatic logic fits_simm(input logic [31:0] v, input int unsigned bits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= bits) ok = ok & (v[i] == v[bits-1]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I field packer: scatters the decoded fields into a
// 32-bit word by format and flags opcode/format mismatches and
// out-of-range immediates.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Pack the word and judge legality for the selected format.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = (opcode == OP_OP);
      end
      FMT_I: begin
        word  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = ((opcode == OP_OPIMM) || (opcode == OP_LOAD) || (opcode == OP_JALR))
                && fits_simm(imm, 12);
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = (opcode == OP_STORE) && fits_simm(imm, 12);
      end
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = (opcode == OP_BRANCH) && fits_simm(imm, 13) && !imm[0];
      end
      FMT_U: begin
        word  = {imm[31:12], rd, opcode};
        legal = ((opcode == OP_LUI) || (opcode == OP_AUIPC)) && (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = (opcode == OP_JAL) && fits_simm(imm, 21) && !imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded instruction bundles, encodes them and
// writes the words to consecutive instruction-memory addresses through a
// single output register with valid/ready flow control.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [15:0]       MAX_NUM   = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic [15:0]       num_q, num_d;
  logic [15:0]       accepted_q, accepted_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        wr_hs;
  logic        accept;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  // A new bundle fits when the output register is empty or draining this cycle.
  assign in_ready = (state_q == ST_LOAD) && (!mem_we_q || mem_ready) && (accepted_q < num_q);
  assign wr_hs    = mem_we_q && mem_ready;
  assign accept   = in_valid && in_ready;

  // Next-state logic: session control, output register and error counters.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    accepted_d  = accepted_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          err_cnt_d  = 8'd0;
          accepted_d = 16'd0;
          num_d      = (num_words > MAX_NUM) ? MAX_NUM : num_words;
          mem_addr_d = base_addr & ALIGN_MSK;
          state_d    = (num_words == 16'd0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // mem_addr always holds the address of the next word to be written.
        if (wr_hs) begin
          mem_we_d   = 1'b0;
          mem_addr_d = mem_addr_q + WORD_STEP;
        end
        // Reloading in the same cycle as a drain keeps 1 word/cycle.
        if (accept) begin
          accepted_d = accepted_q + 16'd1;
          if (pack_legal) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = pack_word;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        if ((accepted_d == num_q) && !mem_we_d) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      accepted_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others, independent of statement order.
      state_q     <= state_d;
      num_q       <= num_d;
      accepted_q  <= accepted_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
